qpsram_qpi_ctrl: RTL
====================

# qpsram_qpi_ctrl

Quad-SPI (QPI-mode) burst controller for external PSRAM/flash. It converts a request handshake (24-bit address, byte count) into the command, address, dummy and data nibble sequence on a 4-bit bus, and returns read bytes as a valid-pulsed stream. It sits directly upstream of the DDR clock-generation stage: `sclk_en` drives that stage's `enable`, and the stage's clock output becomes the memory SCLK.

## Interface
Parameters:
- `DUMMY_CYCLES`, 6: SCLK cycles between the last address nibble and the first read-data nibble.
- `SAMPLE_DELAY`, 1: `clock` cycles from an enabled SCLK cycle until its read nibble is captured from `io_in`. Range 1..3.
- `CS_GAP`, 2: minimum `clock` cycles `cs_n` stays high between bursts.

Ports:
- `clock` in 1: single clock. All logic is on its posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle and able to accept.
- `req_addr` in 24: byte address.
- `req_len` in 8: byte count. 0 means 256.
- `rd_data` out 8: read byte.
- `rd_valid` out 1: one-cycle pulse per byte. There is no backpressure.
- `busy` out 1: high from request acceptance until `req_ready` returns.
- `cs_n` out 1: memory chip select.
- `sclk_en` out 1: connects to the DDR clock stage `enable`.
- `io_out` out 4: nibble driven to the memory.
- `io_oe` out 1: output enable for all four IO lines.
- `io_in` in 4: nibble from the memory.

## Operation
- Request acceptance: a request is accepted on a cycle where `req_valid && req_ready`. `req_addr` and `req_len` are latched on that cycle.
- State sequence: IDLE → CMD (2 cycles) → ADDR (6) → DUMMY (`DUMMY_CYCLES`) → DATA (2·len nibble cycles + `SAMPLE_DELAY` trailing) → GAP (`CS_GAP`) → IDLE.
- CMD: sends read command 0xEB, high nibble first.
- ADDR: sends the address nibbles MSB first, `addr[23:20]` through `addr[3:0]`.
- `sclk_en`: high in every CMD, ADDR and DUMMY cycle, and in the 2·len data nibble cycles. Low in the trailing SAMPLE_DELAY cycles, in GAP and in IDLE.
- `io_oe`: high in CMD and ADDR, low otherwise.
- `io_out`: 0 whenever `io_oe` is low.
- `cs_n`: low from the first CMD cycle through the last DATA cycle, high otherwise.
- Byte assembly: the first captured nibble of each pair is the high nibble. `rd_valid` pulses on the cycle after the low nibble is captured.
- `req_ready`: high only in IDLE. `busy` = !`req_ready`.
- Reset, including mid-burst: on the next cycle the state is IDLE, `cs_n`=1, `sclk_en`=0, `io_oe`=0, `io_out`=0, `rd_valid`=0, `rd_data`=0, `req_ready`=1. The partial burst is dropped and no further `rd_valid` is produced.
- `req_valid` while busy: ignored and not queued.

## Timing
- Acceptance is cycle 0. CMD occupies cycles 1–2 and ADDR cycles 3–8. DUMMY occupies 9..8+DUMMY_CYCLES.
- First `rd_valid` arrives 11+DUMMY_CYCLES+SAMPLE_DELAY cycles after acceptance. With default parameters this is cycle 18.
- Subsequent bytes follow every 2 cycles.
- `cs_n` rises the cycle after the last capture. `req_ready` rises CS_GAP cycles after that.

## Configuration
- `QPSRAM_WRITE_EN` defined: adds the ports below.
  - `req_write` in 1.
  - `wr_data` in 8.
  - `wr_next` out 1.
- Write request behaviour (`req_write`=1):
  - Uses command 0x38. There is no DUMMY phase.
  - DATA is 2·len cycles with `io_oe`=1, driving `wr_data`, high nibble first.
  - `wr_next` pulses on the cycle the low nibble is driven. Upstream must present the next byte on the following cycle.
  - There are no trailing SAMPLE_DELAY cycles and no `rd_valid`.
- `QPSRAM_WRITE_EN` undefined: those ports are absent, and every request is a read.

## Structure
- Package `qpsram_pkg` holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, DATA, GAP);
  - command constants CMD_READ=8'hEB and CMD_WRITE=8'h38;
  - phase lengths CMD_NIB=2 and ADDR_NIB=6.
- Sub-module `qpsram_nibble_shift` is a 32-bit load/shift-left-by-4 register. It serves both the CMD/ADDR transmit path and the receive-side nibble-pair assembly.

## Test plan
- Read of addr 0x012345, len 4, with a memory model returning bytes 0xA0..0xA3:
  - `io_out` sequence E,B,0,1,2,3,4,5;
  - `rd_valid` at cycles 18, 20, 22, 24 carrying A0..A3;
  - `cs_n` high at cycle 24 and `req_ready` high at cycle 26.
- len=0: exactly 256 `rd_valid` pulses and 512 data-phase `sclk_en` cycles.
- `SAMPLE_DELAY`=2, `DUMMY_CYCLES`=4: first `rd_valid` at cycle 17. Data is correct with a model delayed by 2 cycles.
- Reset asserted at cycle 12 of a len-8 read: next cycle `cs_n`=1, `sclk_en`=0, `req_ready`=1, and no further `rd_valid`.
- `req_valid` held high continuously, two back-to-back requests: the second is accepted only after `CS_GAP` cycles of `cs_n`=1.
- With `QPSRAM_WRITE_EN`, write of len 2 with data 0x5A, 0xC3:
  - `io_out` data nibbles 5, A, C, 3 with `io_oe`=1;
  - `wr_next` pulses twice;
  - no `rd_valid`.

Source files
------------

// File: rtl/qpsram_pkg.sv
// qpsram_pkg: shared states, opcodes and phase lengths for the QPI burst controller.
// Imported by qpsram_qpi_ctrl and qpsram_nibble_shift.
package qpsram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    GAP
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;
  localparam int         CMD_NIB   = 2;
  localparam int         ADDR_NIB  = 6;

endpackage

// File: rtl/qpsram_nibble_shift.sv
// qpsram_nibble_shift: 32-bit load / shift-left-by-4 register.
// Top nibble feeds the transmit path, bottom nibble the receive byte assembly.
module qpsram_nibble_shift
  import qpsram_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] load_val,
  input  logic [3:0]  din,
  output logic [3:0]  msb_nib,
  output logic [3:0]  lsb_nib
);

  logic [31:0] q;

  // load wins over shift; shift moves toward the MSB
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[27:0], din};
    end
  end

  assign msb_nib = q[31:28];
  assign lsb_nib = q[3:0];

endmodule

// File: rtl/qpsram_qpi_ctrl.sv
// qpsram_qpi_ctrl: QPI burst controller (cmd, addr, dummy, data nibbles).
// Define QPSRAM_WRITE_EN to add write bursts (req_write, wr_data, wr_next).
module qpsram_qpi_ctrl
  import qpsram_pkg::*;
#(
  parameter int DUMMY_CYCLES = 6,
  parameter int SAMPLE_DELAY = 1,
  parameter int CS_GAP       = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        cs_n,
  output logic        sclk_en,
  output logic [3:0]  io_out,
  output logic        io_oe,
  input  logic [3:0]  io_in
`ifdef QPSRAM_WRITE_EN
  ,
  input  logic        req_write,
  input  logic [7:0]  wr_data,
  output logic        wr_next
`endif
);

  state_t                  st;
  logic [9:0]              cnt;
  logic [8:0]              len_q;
  logic [9:0]              nib_total;
  logic [9:0]              data_last;
  logic [3:0]              io_q;
  logic [SAMPLE_DELAY-1:0] pipe;
  logic                    cap;
  logic                    cap_lo;
  logic                    wr_q;
  logic [7:0]              cmd;
  logic                    sh_shift;
  logic [3:0]              sh_din;
  logic [3:0]              sh_msb;
  logic [3:0]              sh_lsb;

`ifdef QPSRAM_WRITE_EN
  assign cmd = req_write ? CMD_WRITE : CMD_READ;

  // direction of the burst is fixed at acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= 1'b0;
    end else if (req_valid && req_ready) begin
      wr_q <= req_write;
    end
  end

  assign io_out  = (wr_q && st == DATA)
                 ? (cnt[0] ? wr_data[3:0] : wr_data[7:4])
                 : io_q;
  assign wr_next = wr_q && st == DATA && cnt[0];
`else
  assign cmd    = CMD_READ;
  assign wr_q   = 1'b0;
  assign io_out = io_q;
`endif

  assign busy      = !req_ready;
  assign nib_total = {len_q, 1'b0};
  assign data_last = wr_q ? nib_total - 10'd1
                          : nib_total + 10'(SAMPLE_DELAY - 1);
  assign cap       = pipe[SAMPLE_DELAY-1];
  assign sh_shift  = (st == CMD)
                   || (st == ADDR && cnt != 10'(ADDR_NIB - 1))
                   || (cap && !cap_lo);
  assign sh_din    = cap ? io_in : 4'h0;

  qpsram_nibble_shift u_shift (
    .clock    (clock),
    .reset    (reset),
    .load     (req_valid && req_ready),
    .shift    (sh_shift),
    .load_val ({cmd[3:0], req_addr, 4'h0}),
    .din      (sh_din),
    .msb_nib  (sh_msb),
    .lsb_nib  (sh_lsb)
  );

  // burst sequencer; every bus output is registered for the coming cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      cs_n      <= 1'b1;
      sclk_en   <= 1'b0;
      io_oe     <= 1'b0;
      io_q      <= '0;
      req_ready <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      pipe      <= '0;
      cap_lo    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      for (int i = SAMPLE_DELAY - 1; i > 0; i--) begin
        pipe[i] <= pipe[i-1];
      end
      pipe[0] <= (st == DATA) && sclk_en && !wr_q;
      if (cap) begin
        if (cap_lo) begin
          rd_data  <= {sh_lsb, io_in};
          rd_valid <= 1'b1;
        end
        cap_lo <= !cap_lo;
      end
      unique case (st)
        IDLE: begin
          if (req_valid) begin
            st        <= CMD;
            cnt       <= '0;
            len_q     <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
            cs_n      <= 1'b0;
            sclk_en   <= 1'b1;
            io_oe     <= 1'b1;
            io_q      <= cmd[7:4];
            req_ready <= 1'b0;
          end
        end
        CMD: begin
          io_q <= sh_msb;
          if (cnt == 10'(CMD_NIB - 1)) begin
            st  <= ADDR;
            cnt <= '0;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        ADDR: begin
          if (cnt == 10'(ADDR_NIB - 1)) begin
            cnt   <= '0;
            io_oe <= wr_q;
            io_q  <= '0;
            st    <= (wr_q || DUMMY_CYCLES == 0) ? DATA : DUMMY;
          end else begin
            cnt  <= cnt + 10'd1;
            io_q <= sh_msb;
          end
        end
        DUMMY: begin
          if (cnt == 10'(DUMMY_CYCLES - 1)) begin
            st  <= DATA;
            cnt <= '0;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        DATA: begin
          cnt     <= cnt + 10'd1;
          sclk_en <= (cnt + 10'd1) < nib_total;
          if (cnt == data_last) begin
            st      <= GAP;
            cnt     <= '0;
            cs_n    <= 1'b1;
            sclk_en <= 1'b0;
            io_oe   <= 1'b0;
          end
        end
        GAP: begin
          if (cnt == 10'(CS_GAP - 1)) begin
            st        <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
